// File: rtl/adc_cmd_scheduler_pkg.sv
// Shared types and constants for the ADS131A0x command scheduler: state
// encoding, the ADC bring-up command table and SPI word field positions.
package adc_sched_pkg;

   typedef enum logic [3:0] {
      ST_IDLE        = 4'd0,
      ST_INIT_ISSUE  = 4'd1,
      ST_INIT_WAIT   = 4'd2,
      ST_INIT_CHECK  = 4'd3,
      ST_READY       = 4'd4,
      ST_HOST_ISSUE  = 4'd5,
      ST_HOST_WAIT   = 4'd6,
      ST_FRAME_ISSUE = 4'd7,
      ST_FRAME_WAIT  = 4'd8,
      ST_ERROR       = 4'd9
   } sched_state_e;

   localparam int INIT_LEN = 6;
   localparam logic [15:0] NULL_CMD = 16'h0000;

   // Entry 0 is the first command sent after enable.
   localparam logic [INIT_LEN-1:0][15:0] INIT_CMD = {
      16'h0555, 16'h0033, 16'h4F0F, 16'h4B68, 16'h0655, 16'h0000
   };
   localparam logic [INIT_LEN-1:0][15:0] INIT_RSP = {
      16'h0555, 16'h0033, 16'h2F0F, 16'h2B68, 16'h0655, 16'hFF04
   };

   localparam int STATUS_MSB = 31;
   localparam int STATUS_LSB = 16;
   localparam int SAMPLE_MSB = 31;
   localparam int SAMPLE_LSB = 8;

endpackage

// File: rtl/adc_cmd_scheduler_if.sv
// Host command channel and SPI word-engine channel of the scheduler.
// master = scheduler side, slave = host / SPI engine side.
interface adc_cmd_scheduler_if;
   logic        host_req_valid;
   logic        host_req_ready;
   logic [15:0] host_req_cmd;
   logic        host_rsp_valid;
   logic [15:0] host_rsp_data;
   logic        spi_start;
   logic [31:0] spi_tx_word;
   logic        spi_cs_hold;
   logic        spi_busy;
   logic        spi_done;
   logic [31:0] spi_rx_word;

   modport master (
      input  host_req_valid, host_req_cmd, spi_busy, spi_done, spi_rx_word,
      output host_req_ready, host_rsp_valid, host_rsp_data,
             spi_start, spi_tx_word, spi_cs_hold
   );

   modport slave (
      output host_req_valid, host_req_cmd, spi_busy, spi_done, spi_rx_word,
      input  host_req_ready, host_rsp_valid, host_rsp_data,
             spi_start, spi_tx_word, spi_cs_hold
   );
endinterface

// File: rtl/adc_cmd_scheduler_drdy_edge_sync.sv
// Two-flop synchroniser for the asynchronous DRDY pin followed by a
// registered one-cycle falling-edge pulse.
module drdy_edge_sync (
   input  logic system_clock,
   input  logic reset,
   input  logic drdy_n_i,
   output logic fall_o
);
   logic meta_q, sync_q, prev_q, fall_q;

   // Synchroniser chain and edge pulse; cleared to 0 so a high pin after reset is not a fall.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= drdy_n_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         fall_q <= prev_q & ~sync_q;
      end
   end

   assign fall_o = fall_q;
endmodule

// File: rtl/adc_cmd_scheduler.sv
// ADS131A0x scheduler: bring-up sequence with retry, then DRDY frame reads
// and host commands sharing one SPI word engine. Optional macro
// ADC_SCHED_OVERRUN_CNT_EN adds a saturating overrun_count output.
module adc_cmd_scheduler
   import adc_sched_pkg::*;
#(
   parameter int WORDS_PER_FRAME = 5,
   parameter int TIMEOUT_CYCLES  = 1024,
   parameter int MAX_RETRY       = 3
) (
   input  logic                 system_clock,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 drdy_n,
   adc_cmd_scheduler_if.master  bus,
   output logic [15:0]          frame_status,
   output logic                 sample_valid,
   output logic [2:0]           sample_index,
   output logic [23:0]          sample_data,
   output logic                 init_done,
   output logic                 error,
   output logic [3:0]           state
`ifdef ADC_SCHED_OVERRUN_CNT_EN
   ,
   output logic [7:0]           overrun_count
`endif
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_FRAME - 1);
   localparam logic [2:0] LAST_INIT = 3'(INIT_LEN - 1);

   sched_state_e   state_q;
   logic [2:0]     init_idx_q, word_q, sample_index_q;
   logic [7:0]     retry_q;
   logic [TW-1:0]  tmo_q;
   logic [15:0]    rx_hi_q, frame_status_q, rsp_data_q;
   logic [23:0]    sample_data_q;
   logic [31:0]    tx_q;
   logic           pending_q, spi_start_q, cs_hold_q, rsp_valid_q, sample_valid_q;
   logic           drdy_fall_s, edge_eff_s, init_done_s, host_ready_s, timeout_s;
   logic [7:0]     rx_pad_unused_s;

   drdy_edge_sync u_drdy_sync (
      .system_clock (system_clock),
      .reset        (reset),
      .drdy_n_i     (drdy_n),
      .fall_o       (drdy_fall_s)
   );

   assign init_done_s  = state_q inside {ST_READY, ST_HOST_ISSUE, ST_HOST_WAIT,
                                         ST_FRAME_ISSUE, ST_FRAME_WAIT};
   assign edge_eff_s   = drdy_fall_s & init_done_s;
   // The live edge is included so a same-cycle host request loses to the frame.
   assign host_ready_s = (state_q == ST_READY) & ~pending_q & ~edge_eff_s & enable;
   assign timeout_s    = (tmo_q == TW'(TIMEOUT_CYCLES));
   assign rx_pad_unused_s = bus.spi_rx_word[7:0];

   // Scheduler state machine with all registered outputs.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         init_idx_q     <= 3'd0;
         retry_q        <= 8'd0;
         word_q         <= 3'd0;
         tmo_q          <= '0;
         rx_hi_q        <= 16'h0000;
         pending_q      <= 1'b0;
         spi_start_q    <= 1'b0;
         tx_q           <= 32'h0000_0000;
         cs_hold_q      <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_data_q     <= 16'h0000;
         frame_status_q <= 16'h0000;
         sample_valid_q <= 1'b0;
         sample_index_q <= 3'd0;
         sample_data_q  <= 24'h00_0000;
      end else begin
         spi_start_q    <= 1'b0;
         rsp_valid_q    <= 1'b0;
         sample_valid_q <= 1'b0;
         if (state_q inside {ST_INIT_WAIT, ST_HOST_WAIT, ST_FRAME_WAIT}) begin
            tmo_q <= tmo_q + 1'b1;
         end
         if (edge_eff_s) begin
            pending_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               if (enable) begin
                  init_idx_q <= 3'd0;
                  retry_q    <= 8'd0;
                  state_q    <= ST_INIT_ISSUE;
               end
            end
            ST_INIT_ISSUE: begin
               if (!bus.spi_busy) begin
                  spi_start_q <= 1'b1;
                  tmo_q       <= '0;
                  tx_q        <= {INIT_CMD[init_idx_q], NULL_CMD};
                  cs_hold_q   <= 1'b0;
                  state_q     <= ST_INIT_WAIT;
               end
            end
            ST_INIT_WAIT: begin
               if (bus.spi_done) begin
                  rx_hi_q <= bus.spi_rx_word[STATUS_MSB:STATUS_LSB];
                  state_q <= ST_INIT_CHECK;
               end else if (timeout_s) begin
                  state_q <= ST_ERROR;
               end
            end
            ST_INIT_CHECK: begin
               if (rx_hi_q == INIT_RSP[init_idx_q]) begin
                  retry_q <= 8'd0;
                  if (init_idx_q == LAST_INIT) begin
                     state_q <= ST_READY;
                  end else begin
                     init_idx_q <= init_idx_q + 3'd1;
                     state_q    <= ST_INIT_ISSUE;
                  end
               end else if (retry_q == 8'(MAX_RETRY)) begin
                  state_q <= ST_ERROR;
               end else begin
                  retry_q <= retry_q + 8'd1;
                  state_q <= ST_INIT_ISSUE;
               end
            end
            ST_READY: begin
               if (!enable) begin
                  pending_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end else if (pending_q || edge_eff_s) begin
                  // Word 0 is launched straight from READY to meet the DRDY latency.
                  word_q    <= 3'd0;
                  tx_q      <= 32'h0000_0000;
                  cs_hold_q <= (LAST_WORD != 3'd0);
                  if (!bus.spi_busy) begin
                     spi_start_q <= 1'b1;
                     tmo_q       <= '0;
                     pending_q   <= 1'b0;
                     state_q     <= ST_FRAME_WAIT;
                  end else begin
                     pending_q <= 1'b1;
                     state_q   <= ST_FRAME_ISSUE;
                  end
               end else if (bus.host_req_valid && host_ready_s) begin
                  tx_q      <= {bus.host_req_cmd, NULL_CMD};
                  cs_hold_q <= 1'b0;
                  if (!bus.spi_busy) begin
                     spi_start_q <= 1'b1;
                     tmo_q       <= '0;
                     state_q     <= ST_HOST_WAIT;
                  end else begin
                     state_q <= ST_HOST_ISSUE;
                  end
               end
            end
            ST_HOST_ISSUE: begin
               if (!bus.spi_busy) begin
                  spi_start_q <= 1'b1;
                  tmo_q       <= '0;
                  state_q     <= ST_HOST_WAIT;
               end
            end
            ST_HOST_WAIT: begin
               if (bus.spi_done) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= bus.spi_rx_word[STATUS_MSB:STATUS_LSB];
                  state_q     <= ST_READY;
               end else if (timeout_s) begin
                  state_q <= ST_ERROR;
               end
            end
            ST_FRAME_ISSUE: begin
               if (!bus.spi_busy) begin
                  spi_start_q <= 1'b1;
                  tmo_q       <= '0;
                  tx_q        <= 32'h0000_0000;
                  cs_hold_q   <= (word_q != LAST_WORD);
                  if (word_q == 3'd0) begin
                     pending_q <= edge_eff_s;
                  end
                  state_q <= ST_FRAME_WAIT;
               end
            end
            ST_FRAME_WAIT: begin
               if (bus.spi_done) begin
                  if (word_q == 3'd0) begin
                     frame_status_q <= bus.spi_rx_word[STATUS_MSB:STATUS_LSB];
                  end else begin
                     sample_valid_q <= 1'b1;
                     sample_index_q <= word_q - 3'd1;
                     sample_data_q  <= bus.spi_rx_word[SAMPLE_MSB:SAMPLE_LSB];
                  end
                  if (word_q == LAST_WORD) begin
                     state_q <= ST_READY;
                  end else begin
                     word_q  <= word_q + 3'd1;
                     state_q <= ST_FRAME_ISSUE;
                  end
               end else if (timeout_s) begin
                  state_q <= ST_ERROR;
               end
            end
            ST_ERROR: begin
               pending_q <= 1'b0;
               if (!enable) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ADC_SCHED_OVERRUN_CNT_EN
   logic [7:0] ovr_q;
   logic       frame_busy_s;

   assign frame_busy_s = state_q inside {ST_FRAME_ISSUE, ST_FRAME_WAIT};

   // Saturating count of DRDY edges that arrive while a frame is already owed or running.
   always_ff @(posedge system_clock) begin
      if (reset) begin
         ovr_q <= 8'd0;
      end else if (edge_eff_s && (pending_q || frame_busy_s) && (ovr_q != 8'hFF)) begin
         ovr_q <= ovr_q + 8'd1;
      end
   end

   assign overrun_count = ovr_q;
`endif

   assign bus.host_req_ready = host_ready_s;
   assign bus.host_rsp_valid = rsp_valid_q;
   assign bus.host_rsp_data  = rsp_data_q;
   assign bus.spi_start      = spi_start_q;
   assign bus.spi_tx_word    = tx_q;
   assign bus.spi_cs_hold    = cs_hold_q;
   assign frame_status       = frame_status_q;
   assign sample_valid       = sample_valid_q;
   assign sample_index       = sample_index_q;
   assign sample_data        = sample_data_q;
   assign init_done          = init_done_s;
   assign error              = (state_q == ST_ERROR);
   assign state              = state_q;
endmodule

// File: tb/tb_adc_cmd_scheduler.sv
// Bench for adc_cmd_scheduler: behavioural ADC/SPI-engine model with
// randomized responses and latencies, directed init/frame/host/error steps.
module tb_adc_cmd_scheduler;
   import adc_sched_pkg::*;

   logic        clk = 1'b0;
   logic        rst, enable, drdy_n;
   logic [15:0] frame_status;
   logic        sample_valid, init_done, error;
   logic [2:0]  sample_index;
   logic [23:0] sample_data;
   logic [3:0]  state;
`ifdef ADC_SCHED_OVERRUN_CNT_EN
   logic [7:0]  overrun_count;
`endif

   adc_cmd_scheduler_if bus ();

   int checks = 0;
   int failures = 0;

   // Response words the ADC will return, written by main, consumed by the model.
   logic [31:0] rsp_arr [0:1023];
   int          rsp_wr = 0;
   int          rsp_rd = 0;
   // Every launched word {cs_hold, tx}, written by the model.
   logic [32:0] sent_arr [0:1023];
   int          sent_n = 0;
   // Observed sample strobes {index, data} and host responses.
   logic [26:0] samp_arr [0:1023];
   int          samp_n = 0;
   int          rsp_cnt = 0;
   logic [15:0] last_rsp = 16'h0000;

   logic withhold;
   int   lat_min, lat_max;

   logic [15:0] init_cmd_tb [6] = '{16'h0000, 16'h0655, 16'h4B68, 16'h4F0F, 16'h0033, 16'h0555};
   logic [15:0] init_rsp_tb [6] = '{16'hFF04, 16'h0655, 16'h2B68, 16'h2F0F, 16'h0033, 16'h0555};

   always #5 clk = ~clk;

   adc_cmd_scheduler dut (
      .system_clock (clk),
      .reset        (rst),
      .enable       (enable),
      .drdy_n       (drdy_n),
      .bus          (bus),
      .frame_status (frame_status),
      .sample_valid (sample_valid),
      .sample_index (sample_index),
      .sample_data  (sample_data),
      .init_done    (init_done),
      .error        (error),
      .state        (state)
`ifdef ADC_SCHED_OVERRUN_CNT_EN
      ,
      .overrun_count (overrun_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_rsp(input logic [31:0] w);
      rsp_arr[rsp_wr] = w;
      rsp_wr++;
   endtask

   // ADC + SPI word engine model: one response word per spi_start.
   initial begin : adc_model
      logic [31:0] w;
      int d;
      bus.spi_busy = 1'b0;
      bus.spi_done = 1'b0;
      bus.spi_rx_word = 32'h0;
      forever begin
         @(negedge clk);
         if (bus.spi_start === 1'b1) begin
            sent_arr[sent_n] = {bus.spi_cs_hold, bus.spi_tx_word};
            sent_n++;
            if (rsp_rd < rsp_wr) begin
               w = rsp_arr[rsp_rd];
               rsp_rd++;
            end else begin
               w = 32'h0;
            end
            bus.spi_busy = 1'b1;
            d = int'($urandom_range(lat_min, lat_max));
            repeat (d) @(negedge clk);
            while (withhold) @(negedge clk);
            bus.spi_busy = 1'b0;
            bus.spi_done = 1'b1;
            bus.spi_rx_word = w;
            @(negedge clk);
            bus.spi_done = 1'b0;
            bus.spi_rx_word = $urandom;
         end
      end
   end

   always @(negedge clk) begin
      if (sample_valid === 1'b1) begin
         samp_arr[samp_n] <= {sample_index, sample_data};
         samp_n <= samp_n + 1;
      end
      if (bus.host_rsp_valid === 1'b1) begin
         rsp_cnt <= rsp_cnt + 1;
         last_rsp <= bus.host_rsp_data;
      end
   end

   task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
      int i = 0;
      while (state !== s && i < budget) begin
         tick(1);
         i++;
      end
      chk(tag, 32'(state), 32'(s));
   endtask

   task automatic reset_dut();
      int i = 0;
      enable = 1'b0;
      withhold = 1'b0;
      while (bus.spi_busy === 1'b1 && i < 2000) begin
         tick(1);
         i++;
      end
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic do_init(input string tag);
      for (int i = 0; i < 6; i++) push_rsp({init_rsp_tb[i], 16'($urandom)});
      enable = 1'b1;
      wait_state(ST_READY, 800, tag);
   endtask

   // Frame expectations: status = word0[31:16], sample k-1 = word k[31:8].
   task automatic run_frame(input logic [31:0] w [5], input bit check_lat, input string tag);
      int sb, pb, lat, i;
      sb = sent_n;
      pb = samp_n;
      for (int k = 0; k < 5; k++) push_rsp(w[k]);
      drdy_n = 1'b0;
      if (check_lat) begin
         lat = 0;
         while (bus.spi_start !== 1'b1 && lat < 20) begin
            tick(1);
            lat++;
         end
         chk({tag, "_drdy_latency"}, 32'(lat), 32'd4);
      end else begin
         tick(4);
      end
      drdy_n = 1'b1;
      i = 0;
      while (((sent_n - sb) < 5 || state !== ST_READY) && i < 400) begin
         tick(1);
         i++;
      end
      tick(1);
      chk({tag, "_words"}, 32'(sent_n - sb), 32'd5);
      chk({tag, "_samples"}, 32'(samp_n - pb), 32'd4);
      chk({tag, "_status"}, 32'(frame_status), 32'(w[0][31:16]));
      for (int k = 0; k < 5; k++) begin
         chk({tag, "_tx"}, sent_arr[sb + k][31:0], 32'h0);
         chk({tag, "_cs_hold"}, 32'(sent_arr[sb + k][32]), (k != 4) ? 32'd1 : 32'd0);
      end
      for (int k = 1; k < 5; k++) begin
         chk({tag, "_sample"}, 32'(samp_arr[pb + k - 1]), {5'd0, 3'(k - 1), w[k][31:8]});
      end
   endtask

   task automatic host_txn(input logic [15:0] cmd, input logic [15:0] rsp, input string tag);
      int sb, rb, i;
      sb = sent_n;
      rb = rsp_cnt;
      push_rsp({rsp, 16'($urandom)});
      bus.host_req_cmd = cmd;
      bus.host_req_valid = 1'b1;
      i = 0;
      while (bus.host_req_ready !== 1'b1 && i < 200) begin
         tick(1);
         i++;
      end
      tick(1);
      bus.host_req_valid = 1'b0;
      chk({tag, "_start_next_cycle"}, 32'(bus.spi_start), 32'd1);
      i = 0;
      while (rsp_cnt == rb && i < 200) begin
         tick(1);
         i++;
      end
      chk({tag, "_rsp_count"}, 32'(rsp_cnt - rb), 32'd1);
      chk({tag, "_rsp_data"}, 32'(last_rsp), 32'(rsp));
      chk({tag, "_tx"}, sent_arr[sb][31:0], {cmd, 16'h0000});
      chk({tag, "_cs_hold"}, 32'(sent_arr[sb][32]), 32'd0);
   endtask

   initial begin : main
      logic [31:0] fw [5];
      int sb, rb, n, i;
      rst = 1'b1;
      enable = 1'b0;
      drdy_n = 1'b1;
      withhold = 1'b0;
      lat_min = 1;
      lat_max = 4;
      bus.host_req_valid = 1'b0;
      bus.host_req_cmd = 16'h0000;
      tick(3);
      chk("rst_state", 32'(state), 32'(ST_IDLE));
      chk("rst_init_done", 32'(init_done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_spi_start", 32'(bus.spi_start), 32'd0);
      chk("rst_tx", bus.spi_tx_word, 32'h0);
      chk("rst_host_ready", 32'(bus.host_req_ready), 32'd0);
      chk("rst_frame_status", 32'(frame_status), 32'd0);
      chk("rst_sample_valid", 32'(sample_valid), 32'd0);
`ifdef ADC_SCHED_OVERRUN_CNT_EN
      chk("rst_overrun", 32'(overrun_count), 32'd0);
`endif
      rst = 1'b0;
      tick(3);
      chk("idle_without_enable", 32'(state), 32'(ST_IDLE));

      // Clean bring-up.
      sb = sent_n;
      do_init("init_ready");
      chk("init_starts", 32'(sent_n - sb), 32'd6);
      for (int k = 0; k < 6; k++) begin
         chk("init_tx", sent_arr[sb + k][31:0], {init_cmd_tb[k], 16'h0000});
         chk("init_cs_hold", 32'(sent_arr[sb + k][32]), 32'd0);
      end
      chk("init_done_high", 32'(init_done), 32'd1);
      chk("init_no_error", 32'(error), 32'd0);

      // Frame read with known words, then random frames and host commands.
      fw = '{32'h2200_0000, 32'h1234_5600, 32'hABCD_EF00, 32'h0000_0100, 32'hFFFF_FF00};
      run_frame(fw, 1'b1, "frame_fixed");
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 5; k++) fw[k] = $urandom;
         run_frame(fw, 1'b0, "frame_rand");
      end
      for (int r = 0; r < 3; r++) host_txn(16'($urandom), 16'($urandom), "host_rand");

      // Same-cycle DRDY edge and host request: frame first, host after.
      sb = sent_n;
      rb = rsp_cnt;
      for (int k = 0; k < 5; k++) fw[k] = $urandom;
      for (int k = 0; k < 5; k++) push_rsp(fw[k]);
      push_rsp(32'h5A5A_1234);
      drdy_n = 1'b0;
      tick(3);
      bus.host_req_cmd = 16'h2500;
      bus.host_req_valid = 1'b1;
      chk("arb_host_stalled", 32'(bus.host_req_ready), 32'd0);
      i = 0;
      while (bus.host_req_ready !== 1'b1 && i < 400) begin
         tick(1);
         i++;
      end
      tick(1);
      bus.host_req_valid = 1'b0;
      drdy_n = 1'b1;
      i = 0;
      while (rsp_cnt == rb && i < 400) begin
         tick(1);
         i++;
      end
      chk("arb_total_words", 32'(sent_n - sb), 32'd6);
      chk("arb_frame_first", sent_arr[sb][32:0], {1'b1, 32'h0});
      chk("arb_host_last", sent_arr[sb + 5][31:0], 32'h2500_0000);
      chk("arb_frame_status", 32'(frame_status), 32'(fw[0][31:16]));
      chk("arb_host_rsp", 32'(last_rsp), 32'h0000_5A5A);

      // Retry: 0655 answered wrongly twice, then correctly.
      reset_dut();
      sb = sent_n;
      push_rsp(32'hFF04_0000);
      push_rsp(32'h0000_0000);
      push_rsp(32'h0000_0000);
      for (int k = 1; k < 6; k++) push_rsp({init_rsp_tb[k], 16'h0000});
      enable = 1'b1;
      wait_state(ST_READY, 1000, "retry_ready");
      n = 0;
      for (int k = sb; k < sent_n; k++) if (sent_arr[k][31:16] == 16'h0655) n++;
      chk("retry_0655_issues", 32'(n), 32'd3);
      chk("retry_total_issues", 32'(sent_n - sb), 32'd8);

      // Retry exhausted: four wrong answers end in ERROR.
      reset_dut();
      sb = sent_n;
      push_rsp(32'hFF04_0000);
      for (int k = 0; k < 4; k++) push_rsp(32'h0000_0000);
      enable = 1'b1;
      wait_state(ST_ERROR, 1000, "exhaust_error_state");
      chk("exhaust_error", 32'(error), 32'd1);
      chk("exhaust_init_done", 32'(init_done), 32'd0);
      n = 0;
      for (int k = sb; k < sent_n; k++) if (sent_arr[k][31:16] == 16'h0655) n++;
      chk("exhaust_0655_issues", 32'(n), 32'd4);
      n = sent_n;
      tick(20);
      chk("error_no_start", 32'(sent_n - n), 32'd0);
      enable = 1'b0;
      tick(2);
      chk("error_exit_idle", 32'(state), 32'(ST_IDLE));
      chk("error_cleared", 32'(error), 32'd0);

      // Timeout on a withheld spi_done.
      reset_dut();
      do_init("tmo_init");
      withhold = 1'b1;
      sb = sent_n;
      drdy_n = 1'b0;
      tick(4);
      drdy_n = 1'b1;
      i = 0;
      while (sent_n == sb && i < 50) begin
         tick(1);
         i++;
      end
      tick(1000);
      chk("tmo_not_yet", 32'(error), 32'd0);
      i = 0;
      while (error !== 1'b1 && i < 100) begin
         tick(1);
         i++;
      end
      chk("tmo_error", 32'(error), 32'd1);
      chk("tmo_state", 32'(state), 32'(ST_ERROR));
      enable = 1'b0;
      tick(2);
      chk("tmo_idle", 32'(state), 32'(ST_IDLE));
      chk("tmo_error_clear", 32'(error), 32'd0);
      withhold = 1'b0;
      tick(10);
      chk("stray_done_idle", 32'(state), 32'(ST_IDLE));

      // Two DRDY edges inside one slow frame: exactly one extra frame.
      reset_dut();
      do_init("ovr_init");
      lat_min = 20;
      lat_max = 20;
      sb = sent_n;
      for (int k = 0; k < 10; k++) push_rsp($urandom);
      for (int p = 0; p < 3; p++) begin
         drdy_n = 1'b0;
         tick(4);
         drdy_n = 1'b1;
         tick(4);
      end
      i = 0;
      while (((sent_n - sb) < 10 || state !== ST_READY) && i < 1000) begin
         tick(1);
         i++;
      end
      tick(60);
      chk("ovr_words", 32'(sent_n - sb), 32'd10);
`ifdef ADC_SCHED_OVERRUN_CNT_EN
      chk("ovr_count", 32'(overrun_count), 32'd2);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/adc_cmd_scheduler.md
# adc_cmd_scheduler

Sequencer and arbiter sitting between the ADS131A0x-facing SPI word engine and the rest of the FPGA. After enable it runs the fixed ADC bring-up command sequence (with response checking and bounded retry), then shares the SPI engine between DRDY-triggered conversion-frame reads and host register commands. It unpacks each conversion frame into a status word plus per-channel 24-bit samples.

## Interface
Parameters:
- WORDS_PER_FRAME, 5: SPI words per conversion frame; 1 status word plus N-1 channel words, legal range 2..8.
- TIMEOUT_CYCLES, 1024: maximum system_clock cycles from spi_start to spi_done.
- MAX_RETRY, 3: re-issues allowed per init command after a mismatch.

Ports (one clock; reset is synchronous and active-high):
- system_clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  starts init from IDLE; low returns the block to IDLE from READY or ERROR.
- drdy_n  in  1  ADC DRDY, asynchronous, active-low.
- host_req_valid  in  1  host command request.
- host_req_ready  out  1  request accepted when high together with valid.
- host_req_cmd  in  16  command word, sent in tx[31:16].
- host_rsp_valid  out  1  one-cycle response strobe.
- host_rsp_data  out  16  rx[31:16] of the host transaction.
- spi_start  out  1  one-cycle pulse that launches one 32-bit word.
- spi_tx_word  out  32  word to shift out; held stable from spi_start to spi_done.
- spi_cs_hold  out  1  high keeps CS low after this word (multi-word frame).
- spi_busy  in  1  engine busy.
- spi_done  in  1  one-cycle pulse; spi_rx_word valid in the same cycle.
- spi_rx_word  in  32  received word.
- frame_status  out  16  status word (rx[31:16] of word 0) of the last frame.
- sample_valid  out  1  one-cycle strobe per channel word.
- sample_index  out  3  channel number, 0..WORDS_PER_FRAME-2.
- sample_data  out  24  rx[31:8] of the channel word.
- init_done  out  1  high in READY and its sub-states.
- error  out  1  sticky while in ERROR.
- state  out  4  debug: present state encoding.

## Operation
- States: IDLE, INIT_ISSUE, INIT_WAIT, INIT_CHECK, READY, HOST_ISSUE, HOST_WAIT, FRAME_ISSUE, FRAME_WAIT, ERROR.
- IDLE: enable=1 → INIT_ISSUE with init index 0 and retry count 0.
- Init table, command → expected rx[31:16]:
  - 0000 → FF04
  - 0655 → 0655
  - 4B68 → 2B68
  - 4F0F → 2F0F
  - 0033 → 0033
  - 0555 → 0555
- Init command handling: tx = {cmd,16'h0000}, spi_cs_hold=0.
  - INIT_CHECK match: advance the index and clear the retry count; after the last entry → READY.
  - INIT_CHECK mismatch: re-issue the same command and increment the retry count.
  - A mismatch with retry count = MAX_RETRY → ERROR.
- DRDY handling: drdy_n passes through a 2-flop synchroniser, then falling-edge detect. The edge sets pending_frame only while init_done=1.
- READY arbitration: pending_frame has priority → FRAME_ISSUE. Otherwise, host_req_valid&host_req_ready → HOST_ISSUE. host_req_ready = (state==READY) & !pending_frame & enable.
- Frame read:
  - Word k (0..N-1): tx = 32'h0; spi_cs_hold = (k != N-1).
  - Word 0 response → frame_status.
  - Words 1..N-1: sample_valid with sample_index = k-1.
  - pending_frame clears on the spi_start of word 0.
  - After the last word → READY.
- Host transaction: one word, tx = {host_req_cmd,16'h0}, spi_cs_hold=0. On spi_done: host_rsp_valid, then → READY.
- DRDY edge while pending_frame is already set (overrun): the flag stays set. At most one frame is pending.
- spi_start is issued only when spi_busy=0; an ISSUE state waits while spi_busy=1.
- Timeout: a counter is cleared at spi_start. If it reaches TIMEOUT_CYCLES in any WAIT state → ERROR.
- ERROR: error=1, init_done=0, no spi_start. enable=0 → IDLE, which clears error.
- enable=0 is acted on only in READY and ERROR. An in-flight init, frame or host transaction completes first.

## Timing
- Reset values: every output is 0 and state=IDLE. Internal flags, counters and the synchroniser are also cleared.
- Latency:
  - drdy_n pin fall → spi_start: 4 cycles (2 sync, 1 edge, 1 state) when in READY with spi_busy=0.
  - spi_done → sample_valid or host_rsp_valid: 1 cycle.
  - spi_done → next spi_start within a frame: 2 cycles.
- A host handshake in cycle t gives spi_start at t+1.
- A DRDY edge and host_req_valid in the same READY cycle: the frame wins and the host stalls (host_req_ready=0).
- reset mid-transaction: reset is immediate. spi_start deasserts next edge; a stray spi_done is ignored in IDLE.

## Configuration
- ADC_SCHED_OVERRUN_CNT_EN, defined:
  - Adds output overrun_count (8 bits, saturating at 255, reset 0).
  - It increments on each DRDY edge seen while pending_frame=1 or a frame read is in progress.
- Undefined: the port and counter are absent and overruns are silently absorbed.

## Structure
- Package adc_sched_pkg:
  - State enum.
  - INIT_LEN=6 and the init command/expected-response arrays.
  - NULL_CMD = 16'h0000.
  - Field-slice constants for status and sample.
- Sub-module drdy_edge_sync: 2-flop synchroniser plus registered falling-edge pulse, with its own system_clock/reset.

## Test plan
- Init: ADC model returns FF04, 0655, 2B68, 2F0F, 0033, 0555 → exactly 6 spi_start, then init_done=1 and state=READY.
- Retry: 0655 step answered 0000 twice, then 0655 → 3 issues of 0655, then sequence continues. Answered 0000 four times with MAX_RETRY=3 → error=1.
- Frame: drdy_n falls, rx words 2200_0000, 123456_00, ABCDEF_00, 000001_00, FFFFFF_00 → frame_status=2200; samples (0,123456) (1,ABCDEF) (2,000001) (3,FFFFFF); spi_cs_hold=1,1,1,1,0.
- Arbitration: DRDY edge and host_req_valid with cmd 2500 in the same cycle → frame runs first, then the host word. host_rsp_data equals the model's rx[31:16].
- Timeout: spi_done withheld for 1024 cycles → error=1. enable=0 → IDLE, error=0.
- Overrun (macro on): two DRDY edges during one frame → overrun_count=2, exactly one extra frame read follows.
